// File: rtl/rsa_pkg.sv
// Shared types and defaults for the modular-exponentiation engine scheduler.
`timescale 1ns/1ps
package rsa_pkg;

   localparam int DEF_W           = 32;
   localparam int DEF_TIMEOUT_CYC = 4096;

   typedef enum logic [2:0] {
      ST_IDLE    = 3'd0,
      ST_ISSUE   = 3'd1,
      ST_WAIT    = 3'd2,
      ST_SHORT   = 3'd3,
      ST_RESPOND = 3'd4
   } state_t;

   typedef enum logic [1:0] {
      JOB_ENGINE,
      JOB_ZERO_ERR,
      JOB_ZERO,
      JOB_ONE
   } job_t;

   // Operands that have a fixed answer never reach the engine.
   function automatic job_t classify(input logic mod_zero, input logic mod_one,
                                     input logic exp_zero);
      if (mod_zero)
         return JOB_ZERO_ERR;
      else if (mod_one)
         return JOB_ZERO;
      else if (exp_zero)
         return JOB_ONE;
      else
         return JOB_ENGINE;
   endfunction

endpackage

// File: rtl/rsa_rr_arbiter.sv
// Combinational round-robin search: first requester at or after ptr, wrapping.
`timescale 1ns/1ps
module rsa_rr_arbiter #(
   parameter int NREQ = 2,
   parameter int PW   = 1
) (
   input  logic [NREQ-1:0] req,
   input  logic [PW-1:0]   ptr,
   output logic [NREQ-1:0] grant,
   output logic [PW-1:0]   grant_idx,
   output logic            grant_valid
);

   logic [PW-1:0] cand_idx [NREQ];

   genvar gi;
   generate
      for (gi = 0; gi < NREQ; gi++) begin : g_cand
         assign cand_idx[gi] = PW'((int'(ptr) + gi) % NREQ);
      end
   endgenerate

   // Walk candidates from furthest to nearest so the nearest valid one wins.
   always_comb begin
      grant_idx = '0;
      for (int k = NREQ - 1; k >= 0; k--) begin
         if (req[cand_idx[k]])
            grant_idx = cand_idx[k];
      end
      grant_valid        = |req;
      grant              = '0;
      grant[grant_idx]   = grant_valid;
   end

endmodule

// File: rtl/rsa_modexp_arbiter.sv
// Shares one modexp engine between NREQ requesters: round-robin accept,
// trivial-operand shortcut, engine watchdog, and per-owner response handshake.
`timescale 1ns/1ps
module rsa_modexp_arbiter
   import rsa_pkg::*;
#(
   parameter int NREQ        = 2,
   parameter int W           = DEF_W,
   parameter int TIMEOUT_CYC = DEF_TIMEOUT_CYC
) (
   input  logic            clk,
   input  logic            reset,
   input  logic [NREQ-1:0] req_valid,
   output logic [NREQ-1:0] req_ready,
   input  logic [NREQ*W-1:0] req_base,
   input  logic [NREQ*W-1:0] req_exp,
   input  logic [NREQ*W-1:0] req_mod,
   output logic [NREQ-1:0] rsp_valid,
   input  logic [NREQ-1:0] rsp_ready,
   output logic [W-1:0]    rsp_data,
   output logic            rsp_err,
   output logic            eng_start,
   output logic            eng_abort,
   output logic [W-1:0]    eng_base,
   output logic [W-1:0]    eng_exp,
   output logic [W-1:0]    eng_mod,
   input  logic            eng_done,
   input  logic [W-1:0]    eng_result,
   output logic            busy
);

   localparam int PW  = (NREQ > 1) ? $clog2(NREQ) : 1;
   localparam int WDW = $clog2(TIMEOUT_CYC) + 1;
   // Abort is registered, so it is launched one count early to land on expiry.
   localparam logic [WDW-1:0] WD_LAST = WDW'(TIMEOUT_CYC - 2);

   state_t          state_reg;
   job_t            job_reg;
   job_t            job_next;
   logic [PW-1:0]   ptr_reg;
   logic [PW-1:0]   owner_reg;
   logic [WDW-1:0]  wd_reg;

   logic [NREQ-1:0] grant;
   logic [PW-1:0]   grant_idx;
   logic            grant_valid;
   logic [NREQ-1:0] owner_onehot;
   logic [W-1:0]    base_arr [NREQ];
   logic [W-1:0]    exp_arr  [NREQ];
   logic [W-1:0]    mod_arr  [NREQ];
   logic [W-1:0]    g_base, g_exp, g_mod;

   genvar gi;
   generate
      for (gi = 0; gi < NREQ; gi++) begin : g_unpack
         assign base_arr[gi] = req_base[gi*W +: W];
         assign exp_arr[gi]  = req_exp[gi*W +: W];
         assign mod_arr[gi]  = req_mod[gi*W +: W];
      end
   endgenerate

   rsa_rr_arbiter #(.NREQ(NREQ), .PW(PW)) u_rr (
      .req         (req_valid),
      .ptr         (ptr_reg),
      .grant       (grant),
      .grant_idx   (grant_idx),
      .grant_valid (grant_valid)
   );

   assign g_base    = base_arr[grant_idx];
   assign g_exp     = exp_arr[grant_idx];
   assign g_mod     = mod_arr[grant_idx];
   assign job_next  = classify(g_mod == '0, g_mod == W'(1), g_exp == '0);
   assign req_ready = (state_reg == ST_IDLE && !reset) ? grant : '0;
   assign busy      = (state_reg != ST_IDLE);

   always_comb begin
      owner_onehot            = '0;
      owner_onehot[owner_reg] = 1'b1;
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_reg <= ST_IDLE;
         job_reg   <= JOB_ENGINE;
         ptr_reg   <= '0;
         owner_reg <= '0;
         wd_reg    <= '0;
         eng_start <= 1'b0;
         eng_abort <= 1'b0;
         eng_base  <= '0;
         eng_exp   <= '0;
         eng_mod   <= '0;
         rsp_valid <= '0;
         rsp_data  <= '0;
         rsp_err   <= 1'b0;
      end else begin
         eng_start <= 1'b0;
         eng_abort <= 1'b0;
         case (state_reg)
            ST_IDLE: begin
               if (grant_valid) begin
                  owner_reg <= grant_idx;
                  job_reg   <= job_next;
                  eng_base  <= g_base;
                  eng_exp   <= g_exp;
                  eng_mod   <= g_mod;
                  eng_start <= (job_next == JOB_ENGINE);
                  state_reg <= (job_next == JOB_ENGINE) ? ST_ISSUE : ST_SHORT;
               end
            end
            ST_ISSUE: begin
               wd_reg    <= '0;
               state_reg <= ST_WAIT;
            end
            ST_WAIT: begin
               wd_reg <= wd_reg + 1'b1;
               if (eng_done) begin
                  rsp_data  <= eng_result;
                  rsp_err   <= 1'b0;
                  rsp_valid <= owner_onehot;
                  state_reg <= ST_RESPOND;
               end else if (wd_reg == WD_LAST) begin
                  eng_abort <= 1'b1;
                  rsp_data  <= '0;
                  rsp_err   <= 1'b1;
                  rsp_valid <= owner_onehot;
                  state_reg <= ST_RESPOND;
               end
            end
            ST_SHORT: begin
               rsp_data  <= (job_reg == JOB_ONE) ? W'(1) : '0;
               rsp_err   <= (job_reg == JOB_ZERO_ERR);
               rsp_valid <= owner_onehot;
               state_reg <= ST_RESPOND;
            end
            ST_RESPOND: begin
               if (rsp_ready[owner_reg]) begin
                  rsp_valid <= '0;
                  ptr_reg   <= (int'(owner_reg) == NREQ - 1) ? '0 : owner_reg + 1'b1;
                  state_reg <= ST_IDLE;
               end
            end
            default: state_reg <= ST_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_rsa_modexp_arbiter.sv
// Directed bench for rsa_modexp_arbiter with a behavioural engine model.
`timescale 1ns/1ps
module tb_rsa_modexp_arbiter;

   logic        clk, reset;
   logic [1:0]  req_valid, req_ready, rsp_valid, rsp_ready;
   logic [63:0] req_base, req_exp, req_mod;
   logic [31:0] rsp_data, eng_base, eng_exp, eng_mod, eng_result;
   logic        rsp_err, eng_start, eng_abort, eng_done, busy;

   int n_chk = 0;
   int n_err = 0;
   int start_count = 0;
   int eng_delay = 0;

   typedef struct {
      int          req;
      logic [31:0] b, e, m;
      int          delay;
      logic [31:0] data;
      logic        err;
      int          lat;
   } vec_t;

   vec_t vecs [6];

   rsa_modexp_arbiter #(.NREQ(2), .W(32), .TIMEOUT_CYC(16)) dut (
      .clk        (clk),
      .reset      (reset),
      .req_valid  (req_valid),
      .req_ready  (req_ready),
      .req_base   (req_base),
      .req_exp    (req_exp),
      .req_mod    (req_mod),
      .rsp_valid  (rsp_valid),
      .rsp_ready  (rsp_ready),
      .rsp_data   (rsp_data),
      .rsp_err    (rsp_err),
      .eng_start  (eng_start),
      .eng_abort  (eng_abort),
      .eng_base   (eng_base),
      .eng_exp    (eng_exp),
      .eng_mod    (eng_mod),
      .eng_done   (eng_done),
      .eng_result (eng_result),
      .busy       (busy)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic logic [31:0] modexp(input logic [31:0] b, e, m);
      logic [63:0] r, bb;
      r  = 64'd1;
      bb = {32'd0, b} % {32'd0, m};
      for (int i = 0; i < 32; i++) begin
         if (e[i]) r = (r * bb) % {32'd0, m};
         bb = (bb * bb) % {32'd0, m};
      end
      return r[31:0];
   endfunction

   // Engine model: answers eng_delay cycles after eng_start; 0 means never.
   initial begin
      logic [31:0] mres;
      forever begin
         @(negedge clk);
         if (eng_start) begin
            start_count++;
            if (eng_delay > 0) begin
               mres = modexp(eng_base, eng_exp, eng_mod);
               repeat (eng_delay) @(posedge clk);
               #1 eng_result = mres;
               eng_done = 1'b1;
               @(posedge clk);
               #1 eng_done = 1'b0;
            end
         end
      end
   end

   initial begin
      #500000;
      $display("FAIL global_timeout: simulation did not finish, required completion");
      $fatal(1);
   end

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] req_v);
      n_chk++;
      if (act !== req_v) begin
         n_err++;
         $display("FAIL %s: got 0x%0h, required 0x%0h", name, act, req_v);
      end
   endtask

   task automatic set_ops(input int r, input logic [31:0] b, e, m);
      req_base[r*32 +: 32] = b;
      req_exp[r*32 +: 32]  = e;
      req_mod[r*32 +: 32]  = m;
   endtask

   task automatic wait_rsp(input string name, input logic [1:0] ev, input logic [31:0] ed,
                           input logic ee);
      int n;
      n = 0;
      while (rsp_valid == 2'b00 && n < 100) begin
         @(negedge clk);
         n++;
      end
      #1;
      check({name, "_valid"}, 32'(rsp_valid), 32'(ev));
      check({name, "_data"}, rsp_data, ed);
      check({name, "_err"}, 32'(rsp_err), 32'(ee));
      $display("rsp %s: valid=%b data=0x%0h err=%0b", name, rsp_valid, rsp_data, rsp_err);
      rsp_ready = rsp_valid;
      @(negedge clk);
      rsp_ready = 2'b00;
      #1;
   endtask

   task automatic run_job(input int idx, input vec_t v);
      int lat, s0;
      s0        = start_count;
      eng_delay = v.delay;
      set_ops(v.req, v.b, v.e, v.m);
      req_valid = 2'b01 << v.req;
      #1 check("accept_ready", 32'(req_ready), 32'(1) << v.req);
      @(negedge clk);
      req_valid = 2'b00;
      lat = 1;
      while (rsp_valid == 2'b00 && lat < 200) begin
         @(negedge clk);
         lat++;
      end
      check("rsp_latency", lat, v.lat);
      check("rsp_owner", 32'(rsp_valid), 32'(1) << v.req);
      check("rsp_data", rsp_data, v.data);
      check("rsp_err", 32'(rsp_err), 32'(v.err));
      check("eng_start_count", start_count - s0, (v.delay > 0) ? 1 : 0);
      $display("job %0d: req=%0d base=%0d exp=%0d mod=%0d -> data=0x%0h err=%0b lat=%0d",
               idx, v.req, v.b, v.e, v.m, rsp_data, rsp_err, lat);
      rsp_ready = rsp_valid;
      @(negedge clk);
      rsp_ready = 2'b00;
      #1;
      check("rsp_drop", 32'(rsp_valid), 32'd0);
      check("idle_busy", 32'(busy), 32'd0);
   endtask

   initial begin
      int grants [6];
      int ng, nbad_rsp, nbad_rdy, start_cyc, abort_cyc, rsp_cyc, abort_n;

      vecs[0] = '{0, 32'd7, 32'd3,  32'd15,   10, 32'd13, 1'b0, 12};
      vecs[1] = '{0, 32'd5, 32'd0,  32'd15,    0, 32'd1,  1'b0, 2};
      vecs[2] = '{1, 32'd5, 32'd7,  32'd0,     0, 32'd0,  1'b1, 2};
      vecs[3] = '{1, 32'd9, 32'd4,  32'd1,     0, 32'd0,  1'b0, 2};
      vecs[4] = '{1, 32'd3, 32'd5,  32'd7,     3, 32'd5,  1'b0, 5};
      vecs[5] = '{0, 32'd2, 32'd10, 32'd1000,  1, 32'd24, 1'b0, 3};

      reset = 1'b1; req_valid = 2'b00; rsp_ready = 2'b00;
      req_base = '0; req_exp = '0; req_mod = '0;
      eng_done = 1'b0; eng_result = '0;
      repeat (3) @(negedge clk);
      req_valid = 2'b11;
      #1;
      check("reset_req_ready", 32'(req_ready), 32'd0);
      check("reset_rsp_valid", 32'(rsp_valid), 32'd0);
      check("reset_rsp_data", rsp_data, 32'd0);
      check("reset_rsp_err", 32'(rsp_err), 32'd0);
      check("reset_eng_start", 32'(eng_start), 32'd0);
      check("reset_eng_abort", 32'(eng_abort), 32'd0);
      check("reset_eng_mod", eng_mod, 32'd0);
      check("reset_busy", 32'(busy), 32'd0);
      req_valid = 2'b00;
      @(negedge clk);
      reset = 1'b0;
      @(negedge clk);

      // Both requesters held valid: grants must alternate starting at 0.
      set_ops(0, 32'd5, 32'd0, 32'd15);
      set_ops(1, 32'd9, 32'd4, 32'd1);
      rsp_ready = 2'b11;
      req_valid = 2'b11;
      ng = 0;
      for (int c = 0; c < 60 && ng < 6; c++) begin
         #1;
         if (req_ready != 2'b00) begin
            grants[ng] = req_ready[1] ? 1 : 0;
            $display("grant %0d: requester %0d", ng, grants[ng]);
            ng++;
         end
         @(negedge clk);
      end
      req_valid = 2'b00;
      repeat (4) @(negedge clk);
      rsp_ready = 2'b00;
      check("contention_count", ng, 6);
      for (int i = 0; i < 6; i++) check("contention_order", grants[i], i % 2);

      for (int i = 0; i < 6; i++) run_job(i, vecs[i]);

      // Back-pressure: response must hold and requester 1 must wait.
      eng_delay = 0;
      set_ops(0, 32'd5, 32'd0, 32'd15);
      req_valid = 2'b01;
      #1 check("bp_accept", 32'(req_ready), 32'd1);
      @(negedge clk);
      set_ops(1, 32'd9, 32'd4, 32'd1);
      req_valid = 2'b10;
      #1 check("bp_short_ready", 32'(req_ready), 32'd0);
      @(negedge clk);
      nbad_rsp = 0; nbad_rdy = 0;
      for (int c = 0; c < 20; c++) begin
         #1;
         if (rsp_valid !== 2'b01 || rsp_data !== 32'd1 || rsp_err !== 1'b0) nbad_rsp++;
         if (req_ready !== 2'b00) nbad_rdy++;
         @(negedge clk);
      end
      check("bp_rsp_stable_bad_cycles", nbad_rsp, 0);
      check("bp_req_blocked_bad_cycles", nbad_rdy, 0);
      $display("rsp bp_req0: held 20 cycles, data=0x%0h err=%0b", rsp_data, rsp_err);
      rsp_ready = 2'b01;
      @(negedge clk);
      rsp_ready = 2'b00;
      #1 check("bp_req1_ready_after", 32'(req_ready), 32'd2);
      @(negedge clk);
      req_valid = 2'b00;
      wait_rsp("bp_req1", 2'b10, 32'd0, 1'b0);

      // Watchdog: engine never answers.
      eng_delay = 0;
      set_ops(0, 32'd7, 32'd3, 32'd15);
      req_valid = 2'b01;
      start_cyc = -1; abort_cyc = -1; rsp_cyc = -1; abort_n = 0;
      for (int c = 0; c < 60; c++) begin
         #1;
         if (eng_start) start_cyc = c;
         if (eng_abort) begin abort_cyc = c; abort_n++; end
         if (rsp_valid != 2'b00) begin rsp_cyc = c; break; end
         @(negedge clk);
         req_valid = 2'b00;
      end
      check("to_start_cycle", start_cyc, 1);
      check("to_abort_cycle", abort_cyc, 17);
      check("to_rsp_cycle", rsp_cyc, 17);
      check("to_rsp_data", rsp_data, 32'd0);
      check("to_rsp_err", 32'(rsp_err), 32'd1);
      @(negedge clk);
      #1 check("to_abort_width", 32'(eng_abort), 32'd0);
      check("to_abort_count", abort_n, 1);
      eng_result = 32'd99;
      eng_done = 1'b1;
      @(negedge clk);
      eng_done = 1'b0;
      #1;
      check("late_done_valid", 32'(rsp_valid), 32'd1);
      check("late_done_data", rsp_data, 32'd0);
      check("late_done_err", 32'(rsp_err), 32'd1);
      $display("rsp timeout: abort at %0d, data=0x%0h err=%0b", abort_cyc, rsp_data, rsp_err);
      rsp_ready = 2'b01;
      @(negedge clk);
      rsp_ready = 2'b00;

      // Reset while waiting on the engine, then a clean job from requester 1.
      eng_delay = 0;
      set_ops(0, 32'd7, 32'd3, 32'd15);
      req_valid = 2'b01;
      @(negedge clk);
      set_ops(1, 32'd3, 32'd5, 32'd7);
      req_valid = 2'b10;
      repeat (3) @(negedge clk);
      #1 check("rst_pre_busy", 32'(busy), 32'd1);
      reset = 1'b1;
      #1;
      check("rst_busy", 32'(busy), 32'd0);
      check("rst_req_ready", 32'(req_ready), 32'd0);
      check("rst_rsp_valid", 32'(rsp_valid), 32'd0);
      check("rst_eng_abort", 32'(eng_abort), 32'd0);
      check("rst_eng_base", eng_base, 32'd0);
      check("rst_eng_mod", eng_mod, 32'd0);
      eng_delay = 3;
      @(negedge clk);
      @(negedge clk);
      reset = 1'b0;
      #1 check("rst_new_grant", 32'(req_ready), 32'd2);
      @(negedge clk);
      req_valid = 2'b00;
      wait_rsp("rst_req1", 2'b10, 32'd5, 1'b0);

      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end

endmodule
